// File: rtl/ssd_view_controller_if.sv
// ssd_view_controller_if: button inputs and display-select outputs of the view controller
interface ssd_view_controller_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_mode;
  logic [4:0] RegisterIndex;
  logic       Disp_PC;
  logic       Index_changed;
  modport master (output btn_up, btn_down, btn_mode, input RegisterIndex, Disp_PC, Index_changed);
  modport slave (input btn_up, btn_down, btn_mode, output RegisterIndex, Disp_PC, Index_changed);
endinterface

// File: rtl/ssd_view_controller.sv
// ssd_view_controller: debounced up/down/mode buttons step a 5-bit register index and toggle PC display; define SSD_AUTOREPEAT_EN for hold-to-repeat on up/down
module ssd_view_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 20000000
) (
  input logic clock,
  input logic reset,
  ssd_view_controller_if.slave bus
);
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]       stable_q, stable_d, prev_q, prev_d, ev_q, ev_d;
  logic [2:0][31:0] cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic             disp_q, disp_d, chg_q, chg_d;
  logic             step_up, step_dn;
  // synchronize, debounce and edge-detect; bit 0 up, bit 1 down, bit 2 mode
  always_comb begin
    sync1_d  = {bus.btn_mode, bus.btn_down, bus.btn_up};
    sync2_d  = sync1_q;
    prev_d   = stable_q;
    ev_d     = stable_q & ~prev_q;
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = (sync2_q[i] == stable_q[i] || cnt_q[i] == 32'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q[i] + 32'd1;
      stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] == 32'(DEBOUNCE_CYCLES - 1)) ? sync2_q[i] : stable_q[i];
    end
  end
`ifdef SSD_AUTOREPEAT_EN
  logic [1:0][31:0] rcnt_q, rcnt_d;
  logic [1:0]       rep_q, rep_d;
  // hold timer per direction: first repeat after REPEAT_DELAY, then rearmed to fire every REPEAT_RATE until release
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rep_d[i]  = stable_q[i] && rcnt_q[i] == 32'(REPEAT_DELAY);
      rcnt_d[i] = !stable_q[i] ? '0 : rep_d[i] ? 32'(REPEAT_DELAY - REPEAT_RATE + 1) : rcnt_q[i] + 32'd1;
    end
  end
  // repeat timer state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rcnt_q <= '0;
      rep_q  <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      rep_q  <= rep_d;
    end
  end
  assign step_up = ev_q[0] | rep_q[0];
  assign step_dn = ev_q[1] | rep_q[1];
`else
  assign step_up = ev_q[0];
  assign step_dn = ev_q[1];
`endif
  // index steps wrap mod 32; simultaneous up and down cancel
  always_comb begin
    chg_d  = step_up ^ step_dn;
    idx_d  = chg_d ? (step_up ? idx_q + 5'd1 : idx_q - 5'd1) : idx_q;
    disp_d = disp_q ^ ev_q[2];
  end
  // front-end and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      ev_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      disp_q   <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      ev_q     <= ev_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      chg_q    <= chg_d;
    end
  end
  assign bus.RegisterIndex = idx_q;
  assign bus.Disp_PC       = disp_q;
  assign bus.Index_changed = chg_q;
endmodule
